// File: rtl/cpuc_package.sv
// Shared CPUC definitions: datapath widths, branch types and the truth-word encoding
// produced by the comparator.
package cpuc_package;

  localparam int DATA_WIDTH = 8;
  localparam int PC_WIDTH   = 8;

  typedef enum logic [1:0] {
    BR_NONE     = 2'd0,
    BR_IF_TRUE  = 2'd1,
    BR_IF_FALSE = 2'd2,
    BR_ALWAYS   = 2'd3
  } t_br_type;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RESOLVE = 2'd1,
    FLUSH   = 2'd2
  } t_resolve_state;

  // Comparator encodes booleans as a full word of ones or zeros.
  localparam logic [DATA_WIDTH-1:0] TRUE_WORD  = '1;
  localparam logic [DATA_WIDTH-1:0] FALSE_WORD = '0;

  function automatic logic br_take(input t_br_type t, input logic is_true, input logic is_false);
    return (t == BR_ALWAYS) || ((t == BR_IF_TRUE) && is_true) || ((t == BR_IF_FALSE) && is_false);
  endfunction

endpackage

// File: rtl/cpuc_truth_decode.sv
// Decodes a CPUC truth word into true / false / malformed flags.
module cpuc_truth_decode #(
  parameter int W = 8
) (
  input  logic [W-1:0] word,
  output logic         is_true,
  output logic         is_false,
  output logic         malformed
);

  assign is_true   = &word;
  assign is_false  = ~|word;
  // A 1-bit word is always one or the other, so malformed is constant 0 there.
  assign malformed = ~(is_true | is_false);

endmodule

// File: rtl/cpuc_cond_resolve.sv
// Resolves a branch from a comparator truth word; issues a PC redirect pulse and a
// flush window after taken branches, and counts taken branches with saturation.
module cpuc_cond_resolve
  import cpuc_package::*;
#(
  parameter int DATA_WIDTH   = cpuc_package::DATA_WIDTH,
  parameter int PC_WIDTH     = cpuc_package::PC_WIDTH,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  cond_valid,
  output logic                  cond_ready,
  input  logic [DATA_WIDTH-1:0] cond_word,
  input  t_br_type              br_type,
  input  logic [PC_WIDTH-1:0]   br_target,
  output logic                  redirect_valid,
  output logic [PC_WIDTH-1:0]   redirect_pc,
  output logic                  flush,
  output logic                  taken,
  output logic                  cond_err,
  output logic [CNT_WIDTH-1:0]  taken_cnt
);

  localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES);

  t_resolve_state state;
  logic [3:0]     flush_left;
  logic           is_true;
  logic           is_false;
  logic           malformed;
  logic           take;
  logic           err;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  endfunction

  cpuc_truth_decode #(.W(DATA_WIDTH)) u_decode (
    .word      (cond_word),
    .is_true   (is_true),
    .is_false  (is_false),
    .malformed (malformed)
  );

  assign take       = br_take(br_type, is_true, is_false);
  assign err        = malformed && ((br_type == BR_IF_TRUE) || (br_type == BR_IF_FALSE));
  assign cond_ready = (state == IDLE) && !Rst;

  // Resolution is computed at the accept edge and registered, so the pulses are
  // visible throughout the single RESOLVE cycle.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state          <= IDLE;
      redirect_valid <= 1'b0;
      taken          <= 1'b0;
      flush          <= 1'b0;
      cond_err       <= 1'b0;
      redirect_pc    <= '0;
      taken_cnt      <= '0;
      flush_left     <= '0;
    end else begin
      redirect_valid <= 1'b0;
      taken          <= 1'b0;
      cond_err       <= 1'b0;
      case (state)
        IDLE: begin
          if (cond_valid) begin
            state    <= RESOLVE;
            cond_err <= err;
            if (take) begin
              redirect_valid <= 1'b1;
              taken          <= 1'b1;
              redirect_pc    <= br_target;
              taken_cnt      <= sat_inc(taken_cnt);
            end
          end
        end
        RESOLVE: begin
          if (taken) begin
            state      <= FLUSH;
            flush      <= 1'b1;
            flush_left <= FLUSH_INIT;
          end else begin
            state <= IDLE;
          end
        end
        FLUSH: begin
          if (flush_left == 4'd1) begin
            state      <= IDLE;
            flush      <= 1'b0;
            flush_left <= '0;
          end else begin
            flush_left <= flush_left - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpuc_cond_resolve.sv
// Directed bench for cpuc_cond_resolve (counter narrowed to 4 bits to reach saturation).
module tb_cpuc_cond_resolve;
  import cpuc_package::*;

  logic           Clk = 1'b0;
  logic           Rst;
  logic           cond_valid;
  logic           cond_ready;
  logic [7:0]     cond_word;
  t_br_type       br_type;
  logic [7:0]     br_target;
  logic           redirect_valid;
  logic [7:0]     redirect_pc;
  logic           flush;
  logic           taken;
  logic           cond_err;
  logic [3:0]     taken_cnt;

  logic           w1;
  logic           t1, f1, m1;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 Clk = ~Clk;

  cpuc_cond_resolve #(
    .DATA_WIDTH(8), .PC_WIDTH(8), .FLUSH_CYCLES(2), .CNT_WIDTH(4)
  ) dut (
    .Clk            (Clk),
    .Rst            (Rst),
    .cond_valid     (cond_valid),
    .cond_ready     (cond_ready),
    .cond_word      (cond_word),
    .br_type        (br_type),
    .br_target      (br_target),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .flush          (flush),
    .taken          (taken),
    .cond_err       (cond_err),
    .taken_cnt      (taken_cnt)
  );

  cpuc_truth_decode #(.W(1)) u_dec1 (
    .word      (w1),
    .is_true   (t1),
    .is_false  (f1),
    .malformed (m1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one request once ready; returns at the negedge of the RESOLVE cycle.
  task automatic issue(input t_br_type t, input logic [7:0] w, input logic [7:0] tgt);
    int waited;
    waited = 0;
    while (!cond_ready && waited < 20) begin
      @(negedge Clk);
      waited++;
    end
    if (!cond_ready) chk("issue_ready_timeout", 32'(cond_ready), 32'd1);
    cond_valid = 1'b1;
    br_type    = t;
    cond_word  = w;
    br_target  = tgt;
    @(negedge Clk);
    cond_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pos[3];
    int ntk;
    logic seen;

    Rst = 1'b1; cond_valid = 1'b0; cond_word = 8'h00; br_type = BR_NONE; br_target = 8'h00;
    w1 = 1'b0;

    // Reset held for three cycles
    repeat (3) @(negedge Clk);
    chk("rst_flags", 32'({redirect_valid, taken, flush, cond_err, cond_ready}), 32'd0);
    chk("rst_pc", 32'(redirect_pc), 32'h00);
    chk("rst_cnt", 32'(taken_cnt), 32'd0);
    Rst = 1'b0;
    @(negedge Clk);
    chk("idle_ready", 32'(cond_ready), 32'd1);
    chk("idle_cnt", 32'(taken_cnt), 32'd0);

    // Taken BR_IF_TRUE
    issue(BR_IF_TRUE, 8'hFF, 8'h3C);
    chk("t_rv", 32'(redirect_valid), 32'd1);
    chk("t_pc", 32'(redirect_pc), 32'h3C);
    chk("t_taken", 32'(taken), 32'd1);
    chk("t_noflush_n1", 32'(flush), 32'd0);
    chk("t_notready_n1", 32'(cond_ready), 32'd0);
    @(negedge Clk);
    chk("t_flush_n2", 32'({flush, redirect_valid, taken}), 32'b100);
    @(negedge Clk);
    chk("t_flush_n3", 32'({flush, cond_ready}), 32'b10);
    @(negedge Clk);
    chk("t_end_n4", 32'({flush, cond_ready}), 32'b01);
    chk("t_cnt", 32'(taken_cnt), 32'd1);

    // Not taken BR_IF_TRUE
    issue(BR_IF_TRUE, 8'h00, 8'h55);
    chk("nt_flags", 32'({redirect_valid, taken, cond_err}), 32'd0);
    chk("nt_pc_hold", 32'(redirect_pc), 32'h3C);
    @(negedge Clk);
    chk("nt_ready_n2", 32'({cond_ready, flush}), 32'b10);

    // Taken BR_IF_FALSE
    issue(BR_IF_FALSE, 8'h00, 8'h10);
    chk("f_rv", 32'(redirect_valid), 32'd1);
    chk("f_pc", 32'(redirect_pc), 32'h10);
    chk("f_cnt", 32'(taken_cnt), 32'd2);
    repeat (3) @(negedge Clk);
    chk("f_ready_n4", 32'(cond_ready), 32'd1);

    // Malformed word
    issue(BR_IF_FALSE, 8'h0F, 8'h77);
    chk("m_err", 32'({cond_err, redirect_valid, taken}), 32'b100);
    chk("m_cnt", 32'(taken_cnt), 32'd2);
    @(negedge Clk);
    chk("m_err_pulse", 32'({cond_err, cond_ready}), 32'b01);
    issue(BR_NONE, 8'h0F, 8'h78);
    chk("m_none", 32'({cond_err, redirect_valid}), 32'b00);
    @(negedge Clk);
    issue(BR_ALWAYS, 8'h0F, 8'h20);
    chk("m_always", 32'({cond_err, redirect_valid}), 32'b01);
    chk("m_always_pc", 32'(redirect_pc), 32'h20);
    chk("m_always_cnt", 32'(taken_cnt), 32'd3);
    repeat (3) @(negedge Clk);

    // Back-to-back with cond_valid held
    chk("b2b_start_ready", 32'(cond_ready), 32'd1);
    cond_valid = 1'b1; br_type = BR_ALWAYS; cond_word = 8'h00; br_target = 8'h80;
    ntk = 0;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      @(negedge Clk);
      if (taken && ntk < 3) begin
        pos[ntk] = cyc;
        ntk++;
        if (ntk == 3) cond_valid = 1'b0;
      end
    end
    cond_valid = 1'b0;
    chk("b2b_count", 32'(ntk), 32'd3);
    chk("b2b_pos0", 32'(pos[0]), 32'd1);
    chk("b2b_pos1", 32'(pos[1]), 32'd5);
    chk("b2b_pos2", 32'(pos[2]), 32'd9);
    chk("b2b_cnt", 32'(taken_cnt), 32'd6);

    // Reset during the first flush cycle
    issue(BR_IF_TRUE, 8'hFF, 8'h44);
    chk("ab_rv", 32'(redirect_valid), 32'd1);
    @(negedge Clk);
    chk("ab_flush", 32'(flush), 32'd1);
    Rst = 1'b1;
    @(negedge Clk);
    chk("ab_state", 32'({flush, cond_ready, redirect_valid}), 32'd0);
    chk("ab_pc", 32'(redirect_pc), 32'h00);
    chk("ab_cnt", 32'(taken_cnt), 32'd0);
    Rst = 1'b0;
    seen = 1'b0;
    repeat (4) begin
      @(negedge Clk);
      seen = seen | redirect_valid | flush;
    end
    chk("ab_quiet", 32'(seen), 32'd0);
    chk("ab_ready", 32'(cond_ready), 32'd1);

    // Saturation of the 4-bit counter
    for (int i = 1; i <= 17; i++) begin
      issue(BR_ALWAYS, 8'h00, 8'(i));
      if (i == 14) chk("sat_cnt14", 32'(taken_cnt), 32'hE);
      if (i == 17) chk("sat_rv17", 32'(redirect_valid), 32'd1);
      repeat (3) @(negedge Clk);
    end
    chk("sat_cnt", 32'(taken_cnt), 32'hF);

    // One-bit truth words are never malformed
    w1 = 1'b0; #1;
    chk("w1_zero", 32'({t1, f1, m1}), 32'b010);
    w1 = 1'b1; #1;
    chk("w1_one", 32'({t1, f1, m1}), 32'b100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
